// File: rtl/trigger_conditioner.sv
// trigger_conditioner: synchronizes and debounces a bouncy trigger, adds post-release lockout and counts rejected glitches.
module trigger_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       raw_in,
   output logic       trigger,
   output logic       trig_pulse,
   output logic       busy,
   output logic [7:0] glitch_count
);
   typedef enum logic [2:0] {IDLE, QUAL_H, HIGH, QUAL_L, LOCKOUT} state_t;
   localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);
   localparam state_t     REL_STATE = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
   state_t     state, state_d;
   logic [7:0] cnt, cnt_d;
   logic       sync1, sync_q, trig_d, pulse_d, glitch_inc;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1        <= 1'b0;
         sync_q       <= 1'b0;
         state        <= IDLE;
         cnt          <= 8'd0;
         trigger      <= 1'b0;
         trig_pulse   <= 1'b0;
         glitch_count <= 8'd0;
      end else begin
         sync1      <= raw_in;
         sync_q     <= sync1;
         state      <= state_d;
         cnt        <= cnt_d;
         trigger    <= trig_d;
         trig_pulse <= pulse_d;
         if (glitch_inc && glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
      end
   end
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      trig_d     = trigger;
      pulse_d    = 1'b0;
      glitch_inc = 1'b0;
      case (state)
         IDLE: begin
            trig_d = 1'b0;
            if (sync_q) begin
               state_d = (DEBOUNCE_CYCLES == 1) ? HIGH : QUAL_H;
               cnt_d   = (DEBOUNCE_CYCLES == 1) ? 8'd0 : 8'd1;
               trig_d  = DEBOUNCE_CYCLES == 1;
               pulse_d = DEBOUNCE_CYCLES == 1;
            end
         end
         QUAL_H: begin
            if (!sync_q) begin
               state_d    = IDLE;
               cnt_d      = 8'd0;
               glitch_inc = 1'b1;
            end else if (cnt == DEB_LAST) begin
               state_d = HIGH;
               cnt_d   = 8'd0;
               trig_d  = 1'b1;
               pulse_d = 1'b1;
            end else cnt_d = cnt + 8'd1;
         end
         HIGH: begin
            trig_d = 1'b1;
            if (!sync_q) begin
               state_d = (DEBOUNCE_CYCLES == 1) ? REL_STATE : QUAL_L;
               cnt_d   = (DEBOUNCE_CYCLES == 1) ? 8'd0 : 8'd1;
               trig_d  = DEBOUNCE_CYCLES != 1;
            end
         end
         QUAL_L: begin
            if (sync_q) begin
               state_d    = HIGH;
               cnt_d      = 8'd0;
               glitch_inc = 1'b1;
            end else if (cnt == DEB_LAST) begin
               state_d = REL_STATE;
               cnt_d   = 8'd0;
               trig_d  = 1'b0;
            end else cnt_d = cnt + 8'd1;
         end
         LOCKOUT: begin
            trig_d  = 1'b0;
            state_d = (cnt == LOCK_LAST) ? IDLE : LOCKOUT;
            cnt_d   = (cnt == LOCK_LAST) ? 8'd0 : cnt + 8'd1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            trig_d  = 1'b0;
         end
      endcase
      if (!enable) begin
         state_d    = IDLE;
         cnt_d      = 8'd0;
         trig_d     = 1'b0;
         pulse_d    = 1'b0;
         glitch_inc = 1'b0;
      end
   end
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner: directed table, corner sequences and random stimulus against a run-length reference model.
module tb_trigger_conditioner;
   localparam int D = 4;
   localparam int L = 8;
   logic       clk, reset, enable, raw_in;
   logic       trigger, trig_pulse, busy;
   logic [7:0] glitch_count;
   int checks = 0, errors = 0, pulses = 0;
   logic m_s1, m_s2, m_lvl, m_pulse;
   int   m_run, m_lock, m_glitch;
   typedef struct {
      logic r, e, raw, trig, pulse, busy;
      int   glitch;
   } vec_t;
   vec_t tbl[25];

   trigger_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
      .clk(clk), .reset(reset), .enable(enable), .raw_in(raw_in),
      .trigger(trigger), .trig_pulse(trig_pulse), .busy(busy), .glitch_count(glitch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   // Accepted level changes after D consecutive differing sync samples; any shorter run is a glitch.
   task automatic model_step(input logic r, input logic e, input logic raw);
      logic s;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pulse = 0; m_run = 0; m_lock = 0; m_glitch = 0;
      end else begin
         s = m_s2;
         m_pulse = 0;
         if (!e) begin
            m_lvl = 0; m_run = 0; m_lock = 0;
         end else if (m_lock > 0) m_lock--;
         else if (s != m_lvl) begin
            m_run++;
            if (m_run == D) begin
               m_lvl = s;
               m_run = 0;
               if (s) m_pulse = 1;
               else m_lock = L;
            end
         end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic raw);
      reset = r; enable = e; raw_in = raw;
      @(posedge clk);
      model_step(r, e, raw);
      @(negedge clk);
      chk("trigger", trigger, m_lvl);
      chk("trig_pulse", trig_pulse, m_pulse);
      chk("busy", busy, m_lvl || m_run > 0 || m_lock > 0);
      chk("glitch_count", glitch_count, m_glitch);
      if (trig_pulse) pulses++;
   endtask

   task automatic run(input logic raw, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, raw);
   endtask

   initial begin
      int p0, g0, hold;
      logic rv, ev, rs;
      reset = 1'b1; enable = 1'b0; raw_in = 1'b0;
      model_step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) begin
         tbl[i] = '{r: i == 0, e: 1'b1, raw: (i >= 3 && i <= 9), trig: (i >= 8 && i <= 14),
                    pulse: i == 8, busy: (i >= 5 && i <= 22), glitch: 0};
      end
      tbl[0].trig = 0; tbl[0].busy = 0;
      @(negedge clk);
      for (int i = 0; i < 25; i++) begin
         reset = tbl[i].r; enable = tbl[i].e; raw_in = tbl[i].raw;
         @(posedge clk);
         model_step(tbl[i].r, tbl[i].e, tbl[i].raw);
         @(negedge clk);
         chk("tbl_trigger", trigger, tbl[i].trig);
         chk("tbl_pulse", trig_pulse, tbl[i].pulse);
         chk("tbl_busy", busy, tbl[i].busy);
         chk("tbl_glitch", glitch_count, tbl[i].glitch);
      end
      // High-side bounce: one glitch, one pulse
      cyc(1'b1, 1'b1, 1'b0);
      p0 = pulses;
      run(1'b0, 3); run(1'b1, 2); run(1'b0, 1); run(1'b1, 12);
      chk("bounce_glitch", glitch_count, 1);
      chk("bounce_pulses", pulses - p0, 1);
      chk("bounce_trigger", trigger, 1);
      // Low-side glitch while HIGH
      p0 = pulses;
      run(1'b0, 2); run(1'b1, 8);
      chk("lowglitch_count", glitch_count, 2);
      chk("lowglitch_trigger", trigger, 1);
      chk("lowglitch_pulses", pulses - p0, 0);
      // Release then raw re-asserted during lockout
      p0 = pulses;
      run(1'b0, 7); run(1'b1, 3);
      chk("lockout_trigger", trigger, 0);
      chk("lockout_busy", busy, 1);
      run(1'b1, 12);
      chk("requal_pulses", pulses - p0, 1);
      // enable=0 while HIGH keeps glitch_count, then requalify fresh
      g0 = glitch_count;
      cyc(1'b0, 1'b0, 1'b1);
      chk("dis_trigger", trigger, 0);
      chk("dis_busy", busy, 0);
      chk("dis_glitch", glitch_count, g0);
      p0 = pulses;
      run(1'b1, 8);
      chk("reen_pulses", pulses - p0, 1);
      // Reset mid-QUAL_H clears everything
      run(1'b0, 12); run(1'b1, 4);
      chk("midq_busy", busy, 1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("rst_trigger", trigger, 0);
      chk("rst_busy", busy, 0);
      chk("rst_glitch", glitch_count, 0);
      p0 = pulses;
      run(1'b1, 8);
      chk("rst_rising_pulses", pulses - p0, 1);
      run(1'b0, 20);
      // Saturation
      for (int i = 0; i < 300; i++) begin
         run(1'b1, 1); run(1'b0, 2);
      end
      chk("sat_glitch", glitch_count, 255);
      // Random
      rv = 0;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            rv = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
         end
         hold--;
         ev = $urandom_range(0, 60) != 0;
         rs = $urandom_range(0, 700) == 0;
         cyc(rs, ev, rv);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   always @(negedge clk) begin
      if (trig_pulse && $past(trig_pulse, 2)) begin
      end
   end
endmodule
